// File: rtl/guess_game_ctrl.sv
// Game sequencer for the dual hex-digit guess/secret store.
// It edge-detects enter, steers digits into the store, compares the words and tracks tries.
module guess_game_ctrl #(
  parameter int DIGITS    = 4,
  parameter int MAX_TRIES = 8,
  parameter int TRY_W     = 4,
  parameter int MATCH_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  enter_btn,
  input  logic [4*DIGITS-1:0]   guess_word,
  input  logic [4*DIGITS-1:0]   secret_word,
  output logic                  store_sel,
  output logic                  store_enter,
  output logic                  store_clr,
  output logic [2:0]            digit_cnt,
  output logic [MATCH_W-1:0]    match_cnt,
  output logic [TRY_W-1:0]      tries_left,
  output logic [2:0]            state_o,
  output logic                  win,
  output logic                  lose
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_SEC   = 3'd1,
    LD_GUESS = 3'd2,
    SETTLE   = 3'd3,
    COMPARE  = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  state_t             state;
  logic               enter_q;
  logic               enter_rise;
  logic [MATCH_W-1:0] match_now;

  assign enter_rise = enter_btn & ~enter_q;
  assign state_o    = 3'(state);

  always_comb begin
    match_now = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (guess_word[4*i +: 4] == secret_word[4*i +: 4])
        match_now = match_now + MATCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      enter_q     <= 1'b0;
      store_sel   <= 1'b0;
      store_enter <= 1'b0;
      store_clr   <= 1'b1;
      digit_cnt   <= '0;
      match_cnt   <= '0;
      tries_left  <= TRY_W'(MAX_TRIES);
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      enter_q     <= enter_btn;
      store_enter <= 1'b0;
      store_clr   <= 1'b0;
      if (start) begin
        state      <= LD_SEC;
        store_clr  <= 1'b1;
        store_sel  <= 1'b0;
        digit_cnt  <= '0;
        match_cnt  <= '0;
        tries_left <= TRY_W'(MAX_TRIES);
        win        <= 1'b0;
        lose       <= 1'b0;
      end else begin
        case (state)
          LD_SEC, LD_GUESS: begin
            // store_sel follows the state one cycle late, so the last secret
            // digit's enter pulse still sees the secret register selected.
            store_sel <= (state == LD_GUESS);
            if (enter_rise) begin
              store_enter <= 1'b1;
              if (digit_cnt == 3'(DIGITS - 1)) begin
                digit_cnt <= '0;
                state     <= (state == LD_SEC) ? LD_GUESS : SETTLE;
              end else begin
                digit_cnt <= digit_cnt + 3'd1;
              end
            end
          end
          SETTLE: state <= COMPARE;
          COMPARE: begin
            match_cnt <= match_now;
            if (tries_left != '0)
              tries_left <= tries_left - TRY_W'(1);
            if (match_now == MATCH_W'(DIGITS)) begin
              win   <= 1'b1;
              state <= WIN;
            end else if (tries_left == TRY_W'(1)) begin
              lose  <= 1'b1;
              state <= LOSE;
            end else begin
              state <= LD_GUESS;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl: expected enter pulses and compare
// outcomes are queued as stimulus is driven and checked when the DUT produces them.
module tb_guess_game_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        enter_btn;
  logic [15:0] guess_word;
  logic [15:0] secret_word;
  logic        store_sel;
  logic        store_enter;
  logic        store_clr;
  logic [2:0]  digit_cnt;
  logic [2:0]  match_cnt;
  logic [3:0]  tries_left;
  logic [2:0]  state_o;
  logic        win;
  logic        lose;

  typedef struct {
    logic [2:0] m;
    logic [3:0] t;
    logic       w;
    logic       l;
    logic [2:0] s;
  } cmp_t;

  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  logic        sel_q[$];
  cmp_t        cmp_q[$];
  logic [15:0] secret_m;
  int          tries_m;
  logic [15:0] wrong [7];
  int          p0;

  always #5 clk = ~clk;

  guess_game_ctrl #(
    .DIGITS(4),
    .MAX_TRIES(8),
    .TRY_W(4),
    .MATCH_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .enter_btn(enter_btn),
    .guess_word(guess_word),
    .secret_word(secret_word),
    .store_sel(store_sel),
    .store_enter(store_enter),
    .store_clr(store_clr),
    .digit_cnt(digit_cnt),
    .match_cnt(match_cnt),
    .tries_left(tries_left),
    .state_o(state_o),
    .win(win),
    .lose(lose)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nibble_matches(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++)
      if (a[4*i +: 4] == b[4*i +: 4]) n++;
    return n;
  endfunction

  task automatic monitor();
    logic [2:0] prev_state;
    cmp_t       e;
    prev_state = 3'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_state = 3'd0;
      end else begin
        if (store_enter) begin
          pulse_cnt++;
          check("store_enter_expected", 32'(sel_q.size() != 0), 1);
          if (sel_q.size() != 0)
            check("store_sel_at_enter", store_sel, sel_q.pop_front());
        end
        if (prev_state == 3'd4 && state_o != 3'd4) begin
          check("compare_expected", 32'(cmp_q.size() != 0), 1);
          if (cmp_q.size() != 0) begin
            e = cmp_q.pop_front();
            check("cmp_match_cnt", match_cnt, e.m);
            check("cmp_tries_left", tries_left, e.t);
            check("cmp_win", win, e.w);
            check("cmp_lose", lose, e.l);
            check("cmp_next_state", state_o, e.s);
          end
        end
        prev_state = state_o;
      end
    end
  endtask

  task automatic press(input logic push, input logic sel);
    if (push) sel_q.push_back(sel);
    enter_btn = 1'b1;
    @(negedge clk);
    enter_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tries_m = 8;
    check("start_store_clr", store_clr, 1);
    check("start_state", state_o, 1);
    check("start_digit_cnt", digit_cnt, 0);
    check("start_tries", tries_left, 8);
    check("start_match", match_cnt, 0);
    check("start_win_lose", {win, lose}, 2'b00);
    @(negedge clk);
    check("store_clr_one_cycle", store_clr, 0);
  endtask

  task automatic load_secret(input logic [15:0] word);
    secret_word = word;
    secret_m    = word;
    repeat (4) press(1'b1, 1'b0);
    check("secret_done_state", state_o, 2);
    check("secret_done_digit_cnt", digit_cnt, 0);
  endtask

  task automatic guess(input logic [15:0] word);
    cmp_t e;
    int   m;
    m   = nibble_matches(word, secret_m);
    e.m = 3'(m);
    e.t = 4'(tries_m - 1);
    e.w = (m == 4);
    e.l = (m != 4) && (tries_m == 1);
    e.s = e.w ? 3'd5 : (e.l ? 3'd6 : 3'd2);
    cmp_q.push_back(e);
    tries_m--;
    guess_word = word;
    repeat (3) press(1'b1, 1'b1);
    sel_q.push_back(1'b1);
    enter_btn = 1'b1;
    @(negedge clk);
    check("guess_settle_state", state_o, 3);
    enter_btn = 1'b0;
    @(negedge clk);
    check("guess_compare_state", state_o, 4);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    wrong[0] = 16'h0000; wrong[1] = 16'hA000; wrong[2] = 16'h0BCD; wrong[3] = 16'hDCBA;
    wrong[4] = 16'hABC0; wrong[5] = 16'h1B2D; wrong[6] = 16'hFFFF;
    reset = 1'b1; start = 1'b0; enter_btn = 1'b0;
    guess_word = '0; secret_word = '0; secret_m = '0; tries_m = 8;
    fork
      monitor();
    join_none

    // Reset values, then idle
    repeat (3) @(negedge clk);
    check("rst_store_clr", store_clr, 1);
    check("rst_state", state_o, 0);
    check("rst_tries", tries_left, 8);
    check("rst_outputs", {store_sel, store_enter, digit_cnt, match_cnt, win, lose}, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_state", state_o, 0);
      check("idle_store_clr", store_clr, 0);
      check("idle_tries", tries_left, 8);
      check("idle_win_lose", {win, lose}, 2'b00);
    end

    // Enter in IDLE is dropped
    press(1'b0, 1'b0);
    check("idle_enter_dropped", state_o, 0);

    // Game 1: secret 1234, guess 1234 -> win
    do_start();
    p0 = pulse_cnt;
    secret_word = 16'h1234;
    secret_m    = 16'h1234;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("secret_digit_cnt_mid", digit_cnt, 2);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("secret_pulses", pulse_cnt - p0, 4);
    check("secret_state", state_o, 2);
    guess(16'h1234);
    check("win_state", state_o, 5);
    check("win_flag", win, 1);
    press(1'b0, 1'b0);
    check("win_hold", {state_o, win, match_cnt, tries_left}, {3'd5, 1'b1, 3'd4, 4'd7});

    // Game 2: secret ABCD, eight wrong guesses -> lose
    do_start();
    load_secret(16'hABCD);
    guess(16'hAB00);
    check("partial_state", state_o, 2);
    check("partial_match", match_cnt, 2);
    for (int i = 0; i < 7; i++) guess(wrong[i]);
    check("lose_state", state_o, 6);
    check("lose_flag_tries", {lose, win, tries_left}, {1'b1, 1'b0, 4'd0});
    press(1'b0, 1'b0);
    check("lose_hold", {state_o, lose, tries_left}, {3'd6, 1'b1, 4'd0});

    // Held enter yields exactly one digit
    do_start();
    load_secret(16'h5A5A);
    p0 = pulse_cnt;
    sel_q.push_back(1'b1);
    enter_btn = 1'b1;
    repeat (20) @(negedge clk);
    enter_btn = 1'b0;
    @(negedge clk);
    check("held_digit_cnt", digit_cnt, 1);
    check("held_pulses", pulse_cnt - p0, 1);

    // start coincident with enter edge: start wins
    p0 = pulse_cnt;
    start = 1'b1;
    enter_btn = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("coinc_store_clr", store_clr, 1);
    check("coinc_state", state_o, 1);
    check("coinc_digit_cnt", digit_cnt, 0);
    check("coinc_no_enter", store_enter, 0);
    enter_btn = 1'b0;
    @(negedge clk);
    check("coinc_no_pulse", pulse_cnt - p0, 0);
    tries_m = 8;

    // Reset asserted during COMPARE
    load_secret(16'h0F0F);
    guess_word = 16'h0F0F;
    repeat (3) press(1'b1, 1'b1);
    sel_q.push_back(1'b1);
    enter_btn = 1'b1;
    @(negedge clk);
    enter_btn = 1'b0;
    @(negedge clk);
    check("pre_reset_compare", state_o, 4);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_state", state_o, 0);
    check("midreset_store_clr", store_clr, 1);
    check("midreset_tries", tries_left, 8);
    check("midreset_cnts", {digit_cnt, match_cnt, win, lose}, '0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("final_state", state_o, 0);
    check("sel_queue_drained", sel_q.size(), 0);
    check("cmp_queue_drained", cmp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
